// File: rtl/rgb2yuv_stream.sv
// rgb2yuv_stream: 3-stage streaming RGB->YUV converter, LANES pixels per beat, valid/ready with global stall.
module rgb2yuv_stream #(
  parameter int LANES = 1,
  parameter int IN_WIDTH = 8,
  parameter int COEF_FRAC = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_WIDTH-1:0] in_r,
  input  logic [LANES*IN_WIDTH-1:0] in_g,
  input  logic [LANES*IN_WIDTH-1:0] in_b,
  input  logic [LANES-1:0]          in_pad,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*IN_WIDTH-1:0] out_y,
  output logic [LANES*IN_WIDTH-1:0] out_u,
  output logic [LANES*IN_WIDTH-1:0] out_v,
  output logic                      out_last
);
  localparam int W = IN_WIDTH;
  localparam int PW = W + 10;
  localparam int AW = W + COEF_FRAC + 4;
  localparam logic signed [8:0] COEF [9] = '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128,
                                            9'sd128, -9'sd107, -9'sd21};
  localparam logic signed [AW-1:0] BIAS_Y = AW'(-(1 << (W - 1 + COEF_FRAC)) + (1 << (COEF_FRAC - 1)));
  localparam logic signed [AW-1:0] BIAS_UV = AW'(1 << (COEF_FRAC - 1));
  localparam logic signed [AW-1:0] MAX_V = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] MIN_V = AW'(-(1 << (W - 1)));
  logic en;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
  logic [LANES-1:0][2:0][W-1:0] rgb_q, rgb_d, res_q, res_d;
  logic [LANES-1:0][8:0][PW-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc, sh;
  assign in_ready = en;
  assign out_valid = v3_q;
  assign out_last = l3_q;
  always_comb begin
    en = !v3_q || out_ready;
    v1_d = en ? in_valid : v1_q;
    v2_d = en ? v1_q : v2_q;
    v3_d = en ? v2_q : v3_q;
    l1_d = en ? in_last : l1_q;
    l2_d = en ? l1_q : l2_q;
    l3_d = en ? l2_q : l3_q;
    rgb_d = rgb_q;
    prod_d = prod_q;
    res_d = res_q;
    acc = '0;
    sh = '0;
    out_y = '0;
    out_u = '0;
    out_v = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int c = 0; c < 3; c++)
        if (en) rgb_d[k][c] = in_pad[k] ? '0 : c == 0 ? in_r[k*W +: W] : c == 1 ? in_g[k*W +: W] : in_b[k*W +: W];
      for (int i = 0; i < 9; i++)
        if (en) prod_d[k][i] = PW'(COEF[i]) * PW'($signed({1'b0, rgb_q[k][i%3]}));
      // arithmetic shift floors, so the +half bias gives round-half-up
      for (int c = 0; c < 3; c++) begin
        acc = (c == 0 ? BIAS_Y : BIAS_UV) + AW'($signed(prod_q[k][c*3])) +
              AW'($signed(prod_q[k][c*3+1])) + AW'($signed(prod_q[k][c*3+2]));
        sh = acc >>> COEF_FRAC;
        if (en) res_d[k][c] = sh > MAX_V ? W'(MAX_V) : sh < MIN_V ? W'(MIN_V) : W'(sh);
      end
      out_y[k*W +: W] = res_q[k][0];
      out_u[k*W +: W] = res_q[k][1];
      out_v[k*W +: W] = res_q[k][2];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q} <= '0;
      rgb_q <= '0;
      prod_q <= '0;
      res_q <= '0;
    end else begin
      {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q} <= {v1_d, v2_d, v3_d, l1_d, l2_d, l3_d};
      rgb_q <= rgb_d;
      prod_q <= prod_d;
      res_q <= res_d;
    end
  end
endmodule
